// File: rtl/score_text_writer.sv
// Feeds the HUD text RAM: static "SCORE"/"LIVES" labels after reset, then the score and lives as ASCII on request.
// Optional build macro SCORE_LEADING_BLANK_EN writes leading zero digits as spaces.
module score_text_writer #(
  parameter int ROW_WIDTH = 80,
  parameter int SCORE_COL = 6,
  parameter int LIVES_COL = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        score_update,
  input  logic [15:0] score_in,
  input  logic [2:0]  lives_in,
  output logic [7:0]  ram_addr,
  output logic [7:0]  ram_data,
  output logic        ram_we,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CONVERT,
    S_WRITE_DIGITS,
    S_WRITE_LIVES,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  index_q, index_d;
  logic        pending_q, pending_d;
  logic [15:0] pend_score_q, pend_score_d;
  logic [2:0]  pend_lives_q, pend_lives_d;
  logic [15:0] bin_q, bin_d;
  logic [19:0] bcd_q, bcd_d;
  logic [2:0]  lives_q, lives_d;
  logic [7:0]  ram_addr_q, ram_addr_d;
  logic [7:0]  ram_data_q, ram_data_d;
  logic        ram_we_q, ram_we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef SCORE_LEADING_BLANK_EN
  logic        blank_q, blank_d;
`endif

  logic        start_req;
  logic [15:0] start_score;
  logic [2:0]  start_lives;
  logic [19:0] digit_shift;
  logic [3:0]  digit;
  logic [35:0] dabble;

  // One double-dabble iteration: correct every nibble >= 5, then shift the whole register.
  function automatic logic [35:0] dabble_step(input logic [19:0] bcd, input logic [15:0] bin);
    logic [19:0] adj;
    adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj, bin} << 1;
  endfunction

  function automatic logic [7:0] label_char(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h53;
      4'd1:    return 8'h43;
      4'd2:    return 8'h4F;
      4'd3:    return 8'h52;
      4'd4:    return 8'h45;
      4'd5:    return 8'h4C;
      4'd6:    return 8'h49;
      4'd7:    return 8'h56;
      4'd8:    return 8'h45;
      default: return 8'h53;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    pending_d    = pending_q;
    pend_score_d = pend_score_q;
    pend_lives_d = pend_lives_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    lives_d      = lives_q;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    ram_we_d     = 1'b0;
    done_d       = 1'b0;
`ifdef SCORE_LEADING_BLANK_EN
    blank_d      = blank_q;
`endif

    // The newest request always wins over an older pending capture.
    start_req   = score_update || pending_q;
    start_score = score_update ? score_in : pend_score_q;
    start_lives = score_update ? lives_in : pend_lives_q;
    digit_shift = bcd_q << (4 * index_q);
    digit       = digit_shift[19:16];
    dabble      = dabble_step(bcd_q, bin_q);

    if (score_update && state_q != S_IDLE) begin
      pending_d    = 1'b1;
      pend_score_d = score_in;
      pend_lives_d = lives_in;
    end

    case (state_q)
      S_INIT: begin
        ram_we_d   = 1'b1;
        ram_data_d = label_char(index_q);
        ram_addr_d = (index_q < 4'd5) ? 8'(index_q) : 8'(ROW_WIDTH) + 8'(index_q) - 8'd5;
        if (index_q == 4'd9) begin
          state_d = S_IDLE;
          index_d = 4'd0;
        end else begin
          index_d = index_q + 4'd1;
        end
      end
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) done_d = 1'b1;
        if (start_req) begin
          state_d   = S_CONVERT;
          index_d   = 4'd0;
          bcd_d     = 20'd0;
          bin_d     = start_score;
          lives_d   = start_lives;
          pending_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONVERT: begin
        {bcd_d, bin_d} = dabble;
        if (index_q == 4'd15) begin
          state_d = S_WRITE_DIGITS;
          index_d = 4'd0;
`ifdef SCORE_LEADING_BLANK_EN
          blank_d = 1'b1;
`endif
        end else begin
          index_d = index_q + 4'd1;
        end
      end
      S_WRITE_DIGITS: begin
        ram_we_d   = 1'b1;
        ram_addr_d = 8'(SCORE_COL) + 8'(index_q);
`ifdef SCORE_LEADING_BLANK_EN
        if (blank_q && digit == 4'd0 && index_q != 4'd4) begin
          ram_data_d = 8'h20;
        end else begin
          ram_data_d = 8'h30 + {4'd0, digit};
          blank_d    = 1'b0;
        end
`else
        ram_data_d = 8'h30 + {4'd0, digit};
`endif
        if (index_q == 4'd4) begin
          state_d = S_WRITE_LIVES;
          index_d = 4'd0;
        end else begin
          index_d = index_q + 4'd1;
        end
      end
      S_WRITE_LIVES: begin
        ram_we_d   = 1'b1;
        ram_addr_d = 8'(ROW_WIDTH + LIVES_COL);
        ram_data_d = 8'h30 + {5'd0, lives_q};
        state_d    = S_DONE;
      end
      default: state_d = S_INIT;
    endcase

    // Outputs lag the state by one cycle; busy rises on the accept edge and falls one cycle into IDLE.
    busy_d = !(state_q == S_IDLE && state_d == S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_INIT;
      index_q    <= 4'd0;
      pending_q  <= 1'b0;
      ram_addr_q <= 8'd0;
      ram_data_q <= 8'd0;
      ram_we_q   <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      pending_q  <= pending_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_we_q   <= ram_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge Clk) begin
    pend_score_q <= pend_score_d;
    pend_lives_q <= pend_lives_d;
    bin_q        <= bin_d;
    bcd_q        <= bcd_d;
    lives_q      <= lives_d;
`ifdef SCORE_LEADING_BLANK_EN
    blank_q      <= blank_d;
`endif
  end

  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_we   = ram_we_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_score_text_writer.sv
// Self-checking bench for score_text_writer: label init, table and random updates, pending, DONE overlap, mid-op reset.
module tb_score_text_writer;

  logic        Clk;
  logic        Reset;
  logic        score_update;
  logic [15:0] score_in;
  logic [2:0]  lives_in;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_data;
  logic        ram_we;
  logic        busy;
  logic        done;

  score_text_writer #(.ROW_WIDTH(80), .SCORE_COL(6), .LIVES_COL(6)) dut (
    .Clk(Clk), .Reset(Reset), .score_update(score_update), .score_in(score_in),
    .lives_in(lives_in), .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .busy(busy), .done(done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int unsigned score;
    int unsigned lives;
    logic [39:0] exp_digits;
    logic [7:0]  exp_lives;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int rel = 0;
  int bad_busy = 0;
  int wa[$];
  int wd[$];
  int wc[$];
  int dc[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    rel++;
    if (ram_we) begin
      wa.push_back(int'(ram_addr));
      wd.push_back(int'(ram_data));
      wc.push_back(rel);
      if (!busy) bad_busy++;
    end
    if (done) dc.push_back(rel);
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete(); dc.delete();
    rel = 0;
    bad_busy = 0;
  endtask

  // Decimal digits from plain division, MS first, packed as five ASCII bytes.
  function automatic logic [39:0] ref_digits(input int unsigned s);
    logic [39:0] r;
    int unsigned p;
    int unsigned d;
    bit lead;
    r = '0;
    p = 10000;
    lead = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = (s / p) % 10;
`ifdef SCORE_LEADING_BLANK_EN
      if (lead && d == 0 && i < 4) r[39-8*i -: 8] = 8'h20;
      else begin
        r[39-8*i -: 8] = 8'(8'h30 + d);
        lead = 1'b0;
      end
`else
      r[39-8*i -: 8] = 8'(8'h30 + d);
`endif
      p = p / 10;
    end
    return r;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check("wait_idle_timeout", int'(busy), 0);
  endtask

  // Checks one six-write update sequence in the log, starting at log entry off.
  task automatic expect_seq(input string tag, input int first, input int off,
                            input logic [39:0] d, input logic [7:0] l);
    int ea;
    int ed;
    check({tag, "_count"}, int'(wa.size() >= off + 6), 1);
    if (wa.size() >= off + 6) begin
      for (int i = 0; i < 6; i++) begin
        ea = (i < 5) ? 6 + i : 86;
        ed = (i < 5) ? int'(d[39-8*i -: 8]) : int'(l);
        check({tag, "_cycle"}, wc[off+i], first + i);
        check({tag, "_addr"}, wa[off+i], ea);
        check({tag, "_data"}, wd[off+i], ed);
      end
    end
  endtask

  task automatic run_update(input string tag, input int unsigned s, input int unsigned l,
                            input logic [39:0] d, input logic [7:0] el);
    wait_idle();
    clear_log();
    score_in = 16'(s);
    lives_in = 3'(l);
    score_update = 1'b1;
    @(posedge Clk);
    #1;
    score_update = 1'b0;
    check({tag, "_busy_on_accept"}, int'(busy), 1);
    repeat (24) tick();
    check({tag, "_writes"}, wa.size(), 6);
    expect_seq(tag, 17, 0, d, el);
    check({tag, "_done_count"}, dc.size(), 1);
    if (dc.size() > 0) check({tag, "_done_cycle"}, dc[0], 23);
    check({tag, "_busy_low"}, int'(busy), 0);
    check({tag, "_busy_during_we"}, bad_busy, 0);
  endtask

  task automatic check_init(input string tag);
    logic [79:0] labels;
    labels = "SCORELIVES";
    repeat (40) tick();
    check({tag, "_writes"}, wa.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < wa.size()) begin
        check({tag, "_cycle"}, wc[i], 1 + i);
        check({tag, "_addr"}, wa[i], (i < 5) ? i : 75 + i);
        check({tag, "_data"}, wd[i], int'(labels[79-8*i -: 8]));
      end
    end
    check({tag, "_busy_during_we"}, bad_busy, 0);
    check({tag, "_busy_end"}, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    logic [39:0] rd;
    int unsigned rs;
    int unsigned rl;

    tbl[0] = '{12345, 3, "12345", "3"};
    tbl[1] = '{65535, 7, "65535", "7"};
    tbl[2] = '{9,     5, "00009", "5"};
    tbl[3] = '{10000, 1, "10000", "1"};
`ifdef SCORE_LEADING_BLANK_EN
    tbl[4] = '{0,     0, "    0", "0"};
    tbl[5] = '{100,   2, "  100", "2"};
    tbl[2].exp_digits = "    9";
`else
    tbl[4] = '{0,     0, "00000", "0"};
    tbl[5] = '{100,   2, "00100", "2"};
`endif

    Reset = 1'b1;
    score_update = 1'b0;
    score_in = '0;
    lives_in = '0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("reset_we", int'(ram_we), 0);
    check("reset_busy", int'(busy), 1);
    check("reset_done", int'(done), 0);
    check("reset_addr", int'(ram_addr), 0);
    check("reset_data", int'(ram_data), 0);
    Reset = 1'b0;
    clear_log();
    check_init("init");

    for (int i = 0; i < 6; i++)
      run_update($sformatf("tbl%0d", i), tbl[i].score, tbl[i].lives, tbl[i].exp_digits, tbl[i].exp_lives);

    for (int i = 0; i < 12; i++) begin
      rs = $urandom_range(0, 65535);
      rl = $urandom_range(0, 7);
      rd = ref_digits(rs);
      run_update($sformatf("rnd%0d", i), rs, rl, rd, 8'(8'h30 + rl));
    end

    // Two requests during a running conversion: only the later one is serviced.
    wait_idle();
    clear_log();
    score_in = 16'd50; lives_in = 3'd1; score_update = 1'b1;
    @(posedge Clk); #1;
    score_update = 1'b0;
    repeat (3) tick();
    score_in = 16'd100; lives_in = 3'd2; score_update = 1'b1;
    tick();
    score_update = 1'b0;
    tick();
    score_in = 16'd200; lives_in = 3'd5; score_update = 1'b1;
    tick();
    score_update = 1'b0;
    while (rel < 60) tick();
    check("pend_writes", wa.size(), 12);
    expect_seq("pend_first", 17, 0, ref_digits(50), "1");
    expect_seq("pend_second", 40, 6, ref_digits(200), "5");
    check("pend_done_count", dc.size(), 2);
    if (dc.size() > 1) check("pend_done2_cycle", dc[1], 46);

    // Request landing in the DONE cycle starts the next conversion immediately.
    wait_idle();
    clear_log();
    score_in = 16'd777; lives_in = 3'd4; score_update = 1'b1;
    @(posedge Clk); #1;
    score_update = 1'b0;
    while (rel < 22) tick();
    score_in = 16'd4321; lives_in = 3'd6; score_update = 1'b1;
    tick();
    score_update = 1'b0;
    while (rel < 50) tick();
    check("donecyc_writes", wa.size(), 12);
    expect_seq("donecyc_first", 17, 0, ref_digits(777), "4");
    expect_seq("donecyc_second", 40, 6, ref_digits(4321), "6");
    check("donecyc_done_count", dc.size(), 2);

    // Reset during the digit writes, with a request pending that must be dropped.
    wait_idle();
    clear_log();
    score_in = 16'd999; lives_in = 3'd2; score_update = 1'b1;
    @(posedge Clk); #1;
    score_update = 1'b0;
    while (rel < 9) tick();
    score_in = 16'd111; lives_in = 3'd3; score_update = 1'b1;
    tick();
    score_update = 1'b0;
    while (rel < 19) tick();
    check("midrst_we_before", int'(ram_we), 1);
    Reset = 1'b1;
    tick();
    check("midrst_we_after", int'(ram_we), 0);
    check("midrst_busy", int'(busy), 1);
    check("midrst_addr", int'(ram_addr), 0);
    Reset = 1'b0;
    clear_log();
    check_init("midrst_init");
    check("midrst_no_pending", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
